// File: rtl/step_dir_decoder.sv
// Step/direction receiver: synchronizes STEP/DIR, tracks signed position, counts steps per move,
// checks STEP high/low widths and flags move completion after an idle gap.
module step_dir_decoder #(
  parameter int MIN_HIGH_CYCLE = 5000,
  parameter int MIN_LOW_CYCLE  = 5000,
  parameter int IDLE_TIMEOUT   = 40000
) (
  input  logic        i_Clk,
  input  logic        i_rst_n,
  input  logic        i_step,
  input  logic        i_direction,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [31:0] i_load_pos,
  output logic [31:0] o_position,
  output logic [31:0] o_step_count,
  output logic [31:0] o_move_steps,
  output logic        o_moving,
  output logic        o_move_done,
  output logic        o_err_high,
  output logic        o_err_low
);

  // state  | meaning
  // S_IDLE | no move in progress, waiting for the first step
  // S_HIGH | STEP high, measuring high width
  // S_LOW  | STEP low inside a move, measuring gap / idle timeout
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  localparam logic [19:0] MIN_H  = 20'(MIN_HIGH_CYCLE);
  localparam logic [19:0] MIN_L  = 20'(MIN_LOW_CYCLE);
  localparam logic [19:0] IDLE_T = 20'(IDLE_TIMEOUT);

  state_t      state, state_next;
  logic        step_m, step_s, step_d;
  logic        dir_m, dir_s;
  logic [1:0]  fill;
  logic        armed;
  logic [19:0] cnt;
  logic        edge_rise, edge_fall, rise;
  logic        first, counted, set_eh, set_el, done;

  assign edge_rise = step_s & ~step_d;
  assign edge_fall = ~step_s & step_d;
  assign rise      = edge_rise & armed;

  // fill marks when step_s carries real input data, so a STEP held high through reset never arms
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_m <= 1'b0;
      step_s <= 1'b0;
      step_d <= 1'b0;
      dir_m  <= 1'b0;
      dir_s  <= 1'b0;
      fill   <= 2'b00;
      armed  <= 1'b0;
      cnt    <= 20'd0;
    end else begin
      step_m <= i_step;
      step_s <= step_m;
      step_d <= step_s;
      dir_m  <= i_direction;
      dir_s  <= dir_m;
      fill   <= {fill[0], 1'b1};
      armed  <= armed | (fill[1] & ~step_s);
      if (edge_rise || edge_fall)
        cnt <= 20'd1;
      else if (cnt != '1)
        cnt <= cnt + 20'd1;
    end
  end

  always_comb begin
    state_next = state;
    first      = 1'b0;
    counted    = 1'b0;
    set_eh     = 1'b0;
    set_el     = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_next = S_HIGH;
          first      = 1'b1;
          counted    = 1'b1;
        end
      end
      S_HIGH: begin
        if (edge_fall) begin
          state_next = S_LOW;
          set_eh     = (cnt < MIN_H);
        end
      end
      S_LOW: begin
        if (rise) begin
          state_next = S_HIGH;
          counted    = 1'b1;
          set_el     = (cnt < MIN_L);
        end else if (cnt >= IDLE_T) begin
          state_next = S_IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      o_position   <= 32'd0;
      o_step_count <= 32'd0;
      o_move_steps <= 32'd0;
      o_moving     <= 1'b0;
      o_move_done  <= 1'b0;
      o_err_high   <= 1'b0;
      o_err_low    <= 1'b0;
    end else begin
      state       <= state_next;
      o_move_done <= done;

      if (first)
        o_moving <= 1'b1;
      else if (done)
        o_moving <= 1'b0;

      // a load in the same cycle as a step wins over the position update
      if (i_load)
        o_position <= i_load_pos;
      else if (counted)
        o_position <= dir_s ? o_position + 32'd1 : o_position - 32'd1;

      if (first)
        o_step_count <= 32'd1;
      else if (counted)
        o_step_count <= o_step_count + 32'd1;
      else if (i_clear)
        o_step_count <= 32'd0;

      if (done)
        o_move_steps <= o_step_count;
      else if (i_clear)
        o_move_steps <= 32'd0;

      if (set_eh)
        o_err_high <= 1'b1;
      else if (i_clear)
        o_err_high <= 1'b0;

      if (set_el)
        o_err_low <= 1'b1;
      else if (i_clear)
        o_err_low <= 1'b0;
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder: table of move scenarios plus hand-written corner sequences.
module tb_step_dir_decoder;

  localparam int MIN_H = 50;
  localparam int MIN_L = 50;
  localparam int IDLE  = 400;
  localparam int DONE_LAT = IDLE + 3;  // 2 sync edges + 1 register edge after STEP drops

  logic        i_Clk, i_rst_n, i_step, i_direction, i_clear, i_load;
  logic [31:0] i_load_pos;
  logic [31:0] o_position, o_step_count, o_move_steps;
  logic        o_moving, o_move_done, o_err_high, o_err_low;

  int checks = 0;
  int failures = 0;

  step_dir_decoder #(
    .MIN_HIGH_CYCLE(MIN_H),
    .MIN_LOW_CYCLE (MIN_L),
    .IDLE_TIMEOUT  (IDLE)
  ) dut (
    .i_Clk       (i_Clk),
    .i_rst_n     (i_rst_n),
    .i_step      (i_step),
    .i_direction (i_direction),
    .i_clear     (i_clear),
    .i_load      (i_load),
    .i_load_pos  (i_load_pos),
    .o_position  (o_position),
    .o_step_count(o_step_count),
    .o_move_steps(o_move_steps),
    .o_moving    (o_moving),
    .o_move_done (o_move_done),
    .o_err_high  (o_err_high),
    .o_err_low   (o_err_low)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int          n;
    int          hi;
    int          lo;
    bit          dir;
    bit          do_load;
    logic [31:0] load_val;
    logic [31:0] exp_pos;
    logic [31:0] exp_steps;
    logic [1:0]  exp_err;  // {err_high, err_low}
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo, input bit d);
    i_direction = d;
    i_step = 1'b1;
    repeat (hi) @(negedge i_Clk);
    i_step = 1'b0;
    repeat (lo) @(negedge i_Clk);
  endtask

  // watches a bounded window after STEP drops; reports first o_move_done cycle and pulse count
  task automatic watch_done(output int first_k, output int hits);
    first_k = 0;
    hits = 0;
    for (int k = 1; k <= IDLE + 20; k++) begin
      @(negedge i_Clk);
      if (o_move_done) begin
        hits++;
        if (first_k == 0) first_k = k;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int          lat, hits;
    logic [31:0] prev_pos;

    vecs[0] = '{n:10, hi:100, lo:100, dir:1'b1, do_load:1'b0, load_val:32'h0,
                exp_pos:32'd10, exp_steps:32'd10, exp_err:2'b00};
    vecs[1] = '{n:3, hi:100, lo:100, dir:1'b1, do_load:1'b1, load_val:32'h7FFFFFFE,
                exp_pos:32'h80000001, exp_steps:32'd3, exp_err:2'b00};
    vecs[2] = '{n:2, hi:100, lo:100, dir:1'b0, do_load:1'b0, load_val:32'h0,
                exp_pos:32'h7FFFFFFF, exp_steps:32'd2, exp_err:2'b00};
    vecs[3] = '{n:2, hi:49, lo:49, dir:1'b1, do_load:1'b0, load_val:32'h0,
                exp_pos:32'h80000001, exp_steps:32'd2, exp_err:2'b11};
    vecs[4] = '{n:2, hi:50, lo:50, dir:1'b0, do_load:1'b0, load_val:32'h0,
                exp_pos:32'h7FFFFFFF, exp_steps:32'd2, exp_err:2'b00};
    vecs[5] = '{n:1, hi:100, lo:100, dir:1'b0, do_load:1'b1, load_val:32'h0,
                exp_pos:32'hFFFFFFFF, exp_steps:32'd1, exp_err:2'b00};

    i_rst_n = 1'b1;
    i_step = 1'b0;
    i_direction = 1'b0;
    i_clear = 1'b0;
    i_load = 1'b0;
    i_load_pos = 32'd0;
    #1 i_rst_n = 1'b0;
    repeat (3) @(negedge i_Clk);
    chk("rst_position", o_position, 32'd0);
    chk("rst_step_count", o_step_count, 32'd0);
    chk("rst_move_steps", o_move_steps, 32'd0);
    chk("rst_flags", {28'd0, o_moving, o_move_done, o_err_high, o_err_low}, 32'd0);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_Clk);

    prev_pos = 32'd0;
    for (int r = 0; r < 6; r++) begin
      i_clear = 1'b1;
      @(negedge i_Clk);
      i_clear = 1'b0;
      @(negedge i_Clk);
      chk($sformatf("v%0d_clr_err", r), {30'd0, o_err_high, o_err_low}, 32'd0);
      chk($sformatf("v%0d_clr_count", r), o_step_count, 32'd0);
      chk($sformatf("v%0d_clr_msteps", r), o_move_steps, 32'd0);
      chk($sformatf("v%0d_clr_pos_kept", r), o_position, prev_pos);
      if (vecs[r].do_load) begin
        i_load = 1'b1;
        i_load_pos = vecs[r].load_val;
        @(negedge i_Clk);
        i_load = 1'b0;
        chk($sformatf("v%0d_load", r), o_position, vecs[r].load_val);
      end
      for (int p = 0; p < vecs[r].n; p++)
        pulse(vecs[r].hi, (p == vecs[r].n - 1) ? 0 : vecs[r].lo, vecs[r].dir);
      chk($sformatf("v%0d_moving", r), {31'd0, o_moving}, 32'd1);
      chk($sformatf("v%0d_count", r), o_step_count, vecs[r].exp_steps);
      watch_done(lat, hits);
      chk($sformatf("v%0d_done_lat", r), lat, DONE_LAT);
      chk($sformatf("v%0d_done_hits", r), hits, 32'd1);
      chk($sformatf("v%0d_pos", r), o_position, vecs[r].exp_pos);
      chk($sformatf("v%0d_msteps", r), o_move_steps, vecs[r].exp_steps);
      chk($sformatf("v%0d_err", r), {30'd0, o_err_high, o_err_low}, {30'd0, vecs[r].exp_err});
      chk($sformatf("v%0d_idle", r), {31'd0, o_moving}, 32'd0);
      prev_pos = vecs[r].exp_pos;
    end

    // STEP held high across reset release must not be counted
    i_step = 1'b1;
    i_direction = 1'b1;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_Clk);
    i_rst_n = 1'b1;
    repeat (100) @(negedge i_Clk);
    i_step = 1'b0;
    repeat (10) @(negedge i_Clk);
    chk("hold_pos", o_position, 32'd0);
    chk("hold_count", o_step_count, 32'd0);
    chk("hold_moving", {31'd0, o_moving}, 32'd0);
    pulse(100, 0, 1'b1);
    watch_done(lat, hits);
    chk("hold_pos_after", o_position, 32'd1);
    chk("hold_msteps", o_move_steps, 32'd1);
    chk("hold_done_hits", hits, 32'd1);

    // load lands on the same edge that registers the rise
    i_clear = 1'b1;
    @(negedge i_Clk);
    i_clear = 1'b0;
    i_step = 1'b1;
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_load = 1'b1;
    i_load_pos = 32'd100;
    @(negedge i_Clk);
    i_load = 1'b0;
    chk("ldrise_pos", o_position, 32'd100);
    chk("ldrise_count", o_step_count, 32'd1);
    chk("ldrise_moving", {31'd0, o_moving}, 32'd1);
    repeat (97) @(negedge i_Clk);
    i_step = 1'b0;
    watch_done(lat, hits);
    chk("ldrise_pos_after", o_position, 32'd100);
    chk("ldrise_msteps", o_move_steps, 32'd1);

    // reset in the middle of a high pulse
    i_step = 1'b1;
    repeat (20) @(negedge i_Clk);
    chk("midrst_moving_before", {31'd0, o_moving}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_pos", o_position, 32'd0);
    chk("midrst_count", o_step_count, 32'd0);
    chk("midrst_msteps", o_move_steps, 32'd0);
    chk("midrst_flags", {28'd0, o_moving, o_move_done, o_err_high, o_err_low}, 32'd0);
    @(negedge i_Clk);
    i_step = 1'b0;
    repeat (3) @(negedge i_Clk);
    i_rst_n = 1'b1;
    watch_done(lat, hits);
    chk("midrst_no_done", hits, 32'd0);
    chk("midrst_idle", {31'd0, o_moving}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
